// File: rtl/period_meter_pkg.sv
// Shared types and default sizing for the pulse period meter.
// The state enum and default WIDTH/TIMEOUT used by pulse_period_meter.
package period_meter_pkg;

    typedef enum logic {
        IDLE,
        MEASURE
    } meter_state_e;

    // 27 bits covers one second of a 100 MHz clock (120M cycle timeout < 2^27).
    localparam int unsigned DefaultWidth   = 27;
    localparam int unsigned DefaultTimeout = 120_000_000;

endpackage

// File: rtl/pulse_edge_detect.sv
// Rising-edge detector for the period meter, with an optional two-flop
// synchronizer in front when PERIOD_METER_SYNC_EN is defined.
module pulse_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pulse_i,
    output logic rise_o
);

    logic pulse_s;
    logic pulse_q, pulse_d;

`ifdef PERIOD_METER_SYNC_EN
    logic [1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[0], pulse_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign pulse_s = sync_q[1];
`else
    assign pulse_s = pulse_i;
`endif

    always_comb begin
        pulse_d = pulse_s;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign rise_o = pulse_s & ~pulse_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures cycles between successive rising edges of pulseIn, with lock and
// loss-of-signal indication. Optional input synchronizer: PERIOD_METER_SYNC_EN.
module pulse_period_meter
    import period_meter_pkg::*;
#(
    parameter int unsigned WIDTH   = DefaultWidth,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic             clkIn,
    input  logic             reset,
    input  logic             pulseIn,
    output logic [WIDTH-1:0] period,
    output logic             periodValid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [WIDTH-1:0] CntLimit = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] CntOne   = WIDTH'(1);

    logic rise;

    meter_state_e     state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;

    pulse_edge_detect u_edge_detect (
        .clk_i   (clkIn),
        .rst_i   (reset),
        .pulse_i (pulseIn),
        .rise_o  (rise)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        timeout_d = timeout_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                // First edge only starts the interval; nothing to report yet.
                if (rise) begin
                    state_d = MEASURE;
                    cnt_d   = CntOne;
                end
            end
            MEASURE: begin
                // An edge landing on the limit cycle still counts as a measurement.
                if (rise) begin
                    period_d  = cnt_q;
                    valid_d   = 1'b1;
                    locked_d  = 1'b1;
                    timeout_d = 1'b0;
                    cnt_d     = CntOne;
                end else if (cnt_q == CntLimit) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign period      = period_q;
    assign periodValid = valid_q;
    assign locked      = locked_q;
    assign timeout     = timeout_q;

endmodule

// File: doc/pulse_period_meter.md
# pulse_period_meter

Measures the interval, in `clkIn` cycles, between successive rising edges of a pulse stream such as the 1 Hz tick from our clock divider or an external tick source. It is the inverse of the divider: the divider turns a cycle count into a pulse, and this block turns a pulse into a cycle count. It sits on the consumer side of tick-driven logic and drives display and diagnostic paths with the measured period, a lock indication and a timeout flag.

## Interface
- `WIDTH`, default 27: width of the period counter and of the `period` output.
- `TIMEOUT`, default 120_000_000: cycles without a rising edge before the block declares loss of signal. Must satisfy 2 ≤ `TIMEOUT` ≤ 2^`WIDTH`−1.
- `clkIn` input, 1 bit: the single clock (100 MHz board clock).
- `reset` input, 1 bit: synchronous, active-high reset.
- `pulseIn` input, 1 bit: the pulse stream being measured. Only rising edges are significant.
- `period` output, `WIDTH` bits: the most recent measured edge-to-edge interval, in cycles.
- `periodValid` output, 1 bit: one-cycle strobe; `period` was updated this cycle.
- `locked` output, 1 bit: at least one valid measurement has been made since the last reset or timeout.
- `timeout` output, 1 bit: sticky flag; `TIMEOUT` was reached with no edge.

## Operation
- Edge detect: `rise` = `pulseS` & ~`pulseQ`.
  - `pulseS` is the sampled input.
  - `pulseQ` is `pulseS` delayed by one cycle, with reset value 0.
- Reset values: `period`=0, `periodValid`=0, `locked`=0, `timeout`=0, `cnt`=0, `pulseQ`=0, state=IDLE.
- State IDLE:
  - `cnt` is held at 0.
  - On `rise`: go to MEASURE and set `cnt`<=1.
  - No measurement is produced from the first edge.
- State MEASURE, every cycle `cnt`<=`cnt`+1, except in the two cases below.
  - On `rise`:
    - `period`<=`cnt`, `periodValid`<=1, `locked`<=1, `timeout`<=0.
    - `cnt`<=1; stay in MEASURE.
  - When `cnt`==`TIMEOUT` and there is no `rise`:
    - Go to IDLE.
    - `timeout`<=1, `locked`<=0.
    - `period` keeps its last value and `periodValid` stays 0.
- Simultaneous `rise` and `cnt`==`TIMEOUT`: the edge wins. `period`=`TIMEOUT` is reported as valid.
- The counter saturates by construction: it never exceeds `TIMEOUT`, so it never wraps.
- Minimum reportable period is 2, from an input alternating 1,0,1,0.
- A `pulseIn` held high produces no further edges and ends in timeout.
- A reset mid-measurement discards the partial count. `period` returns to 0.

## Timing
- A periodic input with a rising edge every N cycles (2 ≤ N ≤ `TIMEOUT`) reports `period`=N exactly.
- Latency, without sync: `periodValid` rises one cycle after the cycle in which `pulseIn` is first sampled high.
- Latency, with sync: add 2 cycles.
- `periodValid` is exactly one cycle wide per qualifying edge, and never two consecutive cycles.
- `timeout` rises one cycle after the cycle where `cnt`==`TIMEOUT`. It clears one cycle after the next qualifying measurement.
- All outputs are registered. There are no combinational paths from `pulseIn` to outputs.

## Configuration
- Macro `PERIOD_METER_SYNC_EN`.
  - Defined: `pulseIn` passes through a two-flop synchronizer before edge detection, so `pulseS` is the second flop. For asynchronous or external sources. Latency +2 cycles; measured periods are unchanged.
  - Undefined: `pulseS` = `pulseIn` directly. The source must be synchronous to `clkIn`.

## Structure
- Package `period_meter_pkg` holds:
  - the state enum `{IDLE, MEASURE}`;
  - the default `WIDTH` and `TIMEOUT` constants.
- Sub-module `pulse_edge_detect` contains:
  - the optional synchronizer (the `PERIOD_METER_SYNC_EN` block);
  - the `pulseQ` register.
  It outputs the one-cycle `rise` strobe.
- The top level holds the FSM, the counter and the output registers.

## Test plan
Bench parameters are `WIDTH`=8 and `TIMEOUT`=20 unless stated otherwise.
- **Periodic lock:** 1-cycle pulses every 10 cycles, sent after reset → first edge gives no strobe. Every later edge gives `periodValid` for 1 cycle with `period`=10. `locked`=1 after the second edge.
- **Minimum and boundary:** input alternating 1,0 → `period`=2. Edges exactly 20 cycles apart → `period`=20, `timeout` stays 0.
- **Timeout:** after lock at period 10, stop pulses → `cnt` reaches 20, then `timeout`=1, `locked`=0, `period` holds 10. The next two edges, 7 apart, report `period`=7 and clear `timeout`.
- **Stuck high:** `pulseIn` held high after one edge → timeout after 20 cycles, with no `periodValid`.
- **Reset mid-measure:** assert `reset` 5 cycles after an edge → all outputs 0 next cycle. The next edge is treated as a first edge and produces no strobe.
- **Sync build:** with `PERIOD_METER_SYNC_EN`, repeat the periodic-lock test → identical `period` values, with `periodValid` 2 cycles later. Default parameters with 1 Hz ticks → `period`=100_000_000.
